multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max consecutive cycles a memory state waits for mem_ready before trapping (range 1..255).
REQ-002 SHALL have parameter ENABLE_JAL, default 1: when 1, opcode 000011 (jal) is legal; when 0 it is illegal.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports opcode/func  input  6/6  fields of the instruction register.
REQ-006 SHALL have port eq  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-008 SHALL have outputs PCWrite, IorD, IRWrite, MemRead, MemWrite, RegWrite, ALUsrcA  output  1 each.
REQ-009 SHALL have outputs RegDst, MemtoReg, ALUsrcB, PCsrc  output  2 each; ALUoperation  output  3.
REQ-010 SHALL have outputs state  output  4  current state code; illegal, timeout  output  1  sticky error flags.

Function
REQ-011 SHALL implement a Moore FSM, except PCWrite in BRANCH and the FETCH/MEMRD/MEMWR strobes qualified by mem_ready; codes: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9 IMMEX=10 IMMWB=11 TRAP=12.
REQ-012 All outputs not listed for a state SHALL be 0; ALUoperation default 010 (add).
REQ-013 FETCH: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01; on mem_ready: IRWrite=1, PCWrite=1, PCsrc=00, next DECODE; else stay.
REQ-014 DECODE: ALUsrcA=0, ALUsrcB=11, add; next by opcode: 100011/101011->MEMADR, 000000 with legal func->EXEC, 000100/000101->BRANCH, 000010->JUMP, 000011 (ENABLE_JAL=1)->JUMP, 001000/001100->IMMEX, anything else->TRAP with illegal set.
REQ-015 Legal R-type func and ALUoperation: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other func is illegal.
REQ-016 MEMADR: ALUsrcA=1, ALUsrcB=10, add; next MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: MemRead=1, IorD=1; on mem_ready next MEMWB. MEMWB: RegWrite=1, RegDst=00, MemtoReg=01, next FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; on mem_ready next FETCH.
REQ-019 EXEC: ALUsrcA=1, ALUsrcB=00, ALUoperation per REQ-015; next ALUWB. ALUWB: RegWrite=1, RegDst=01, MemtoReg=00, next FETCH.
REQ-020 BRANCH: ALUsrcA=1, ALUsrcB=00, ALUoperation=110, PCsrc=01, PCWrite=eq (beq) or ~eq (bne); next FETCH.
REQ-021 JUMP: PCWrite=1, PCsrc=10; for jal additionally RegWrite=1, RegDst=10 (r31), MemtoReg=10 (PC+4); next FETCH.
REQ-022 IMMEX: ALUsrcA=1, ALUsrcB=10, ALUoperation 010 (addi) or 000 (andi); next IMMWB. IMMWB: RegWrite=1, RegDst=00, MemtoReg=00, next FETCH.
REQ-023 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR, increment each cycle mem_ready=0 there, saturate; when it reaches MEM_TIMEOUT with mem_ready=0, next state TRAP and timeout set.
REQ-024 mem_ready on the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access normally (ready wins).
REQ-025 TRAP: all enables 0, state held until rst; illegal/timeout remain set until rst.
REQ-026 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=FETCH, counter=0, illegal=0, timeout=0, in any state, mid-wait included.
REQ-028 rst SHALL take priority over all transitions; the first cycle after reset deassertion is FETCH.

Verification
REQ-029 add (000000/100000), mem_ready=1 in FETCH -> states 0,1,6,7,0; ALUoperation=010 in EXEC; RegWrite=1, RegDst=01 in ALUWB.
REQ-030 lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with RegWrite=1, MemtoReg=01; timeout=0.
REQ-031 beq eq=1 -> PCWrite=1, PCsrc=01 in state 8; bne eq=1 -> PCWrite=0; both return to FETCH.
REQ-032 jal with ENABLE_JAL=1 -> JUMP, RegDst=10, MemtoReg=10, RegWrite=1; with ENABLE_JAL=0 -> TRAP, illegal=1.
REQ-033 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles, timeout=1; rst=1 one cycle -> state=0, flags cleared.
REQ-034 R-type func 000111 -> TRAP from DECODE, illegal=1, no RegWrite pulse ever asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle MIPS-style datapath. A Moore FSM steps each
// instruction through fetch, decode and the execute/memory/writeback states
// its opcode needs. Only a few outputs also look at the inputs: PCWrite in
// BRANCH, and the FETCH strobes, which wait for mem_ready.
// Memory states give up after MEM_TIMEOUT cycles without mem_ready. Illegal
// instructions and timeouts park the FSM in TRAP with a sticky flag until
// rst is asserted.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   opcode, func       : instruction register fields
//   eq                 : ALU zero flag, used by beq/bne in BRANCH
//   mem_ready          : memory finishes the current access this cycle
//   PCWrite .. ALUsrcA : 1-bit datapath enables and selects
//   RegDst, MemtoReg,
//   ALUsrcB, PCsrc     : 2-bit datapath selects
//   ALUoperation       : 3-bit ALU control (010 add by default)
//   state              : current state code
//   illegal, timeout   : sticky error flags
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit ENABLE_JAL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       eq,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       ALUsrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUsrcB,
    output logic [1:0] PCsrc,
    output logic [2:0] ALUoperation,
    output logic [3:0] state,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Count value at which one more idle cycle means the access has timed out.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       func_legal;
    logic [2:0] rtype_aluop;
    logic       in_wait_state;
    logic       wait_expired;

    // R-type function decode: ALU operation for each supported func; any
    // other func marks the instruction illegal.
    always_comb begin
        func_legal  = 1'b1;
        rtype_aluop = ALU_ADD;
        case (func)
            6'b100000: rtype_aluop = ALU_ADD;
            6'b100010: rtype_aluop = ALU_SUB;
            6'b100100: rtype_aluop = ALU_AND;
            6'b100101: rtype_aluop = ALU_OR;
            6'b101010: rtype_aluop = ALU_SLT;
            default:   func_legal  = 1'b0;
        endcase
    end

    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                           (state_q == S_MEMWR);
    assign wait_expired  = (wait_cnt_q >= LAST_WAIT);

    // Next-state, wait counter and sticky flags. In a memory state, mem_ready
    // is checked before the timeout, so a late mem_ready still completes the
    // access.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IMMEX;
                    OP_RTYPE: begin
                        if (func_legal) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_JAL: begin
                        if (ENABLE_JAL) begin
                            state_d = S_JUMP;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase

        // The counter runs only while a memory state keeps waiting. Any state
        // change clears it, so each memory state starts counting from zero.
        if (in_wait_state && (state_d == state_q)) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = 8'd0;
        end
    end

    // State register. Reset wins over every transition, including from TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Output decode from the registered state. Everything defaults to 0 with
    // an add on the ALU; each state only lists what it drives.
    always_comb begin
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        ALUsrcA      = 1'b0;
        RegDst       = 2'b00;
        MemtoReg     = 2'b00;
        ALUsrcB      = 2'b00;
        PCsrc        = 2'b00;
        ALUoperation = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUsrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUsrcB = 2'b11;
            S_MEMADR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUsrcA      = 1'b1;
                ALUoperation = rtype_aluop;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BRANCH: begin
                ALUsrcA      = 1'b1;
                ALUoperation = ALU_SUB;
                PCsrc        = 2'b01;
                PCWrite      = (opcode == OP_BNE) ? ~eq : eq;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCsrc   = 2'b10;
                // jal also writes PC+4 into r31.
                if (opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
            end
            S_IMMEX: begin
                ALUsrcA      = 1'b1;
                ALUsrcB      = 2'b10;
                ALUoperation = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            S_IMMWB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Three controllers share one set of inputs: default parameters (a),
// MEM_TIMEOUT=4 (b) and ENABLE_JAL=0 (c). Each scenario queues the inputs
// for every cycle together with the expected outputs of all three. It then
// applies them one cycle at a time and compares the packed outputs on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       eq;
    logic       mem_ready;

    logic pcw_a, iord_a, irw_a, mrd_a, mwr_a, rgw_a, asa_a, ill_a, to_a;
    logic pcw_b, iord_b, irw_b, mrd_b, mwr_b, rgw_b, asa_b, ill_b, to_b;
    logic pcw_c, iord_c, irw_c, mrd_c, mwr_c, rgw_c, asa_c, ill_c, to_c;
    logic [1:0] rdst_a, m2r_a, asb_a, pcs_a;
    logic [1:0] rdst_b, m2r_b, asb_b, pcs_b;
    logic [1:0] rdst_c, m2r_c, asb_c, pcs_c;
    logic [2:0] alu_a, alu_b, alu_c;
    logic [3:0] st_a, st_b, st_c;

    logic [23:0] vec_a, vec_b, vec_c;
    logic [71:0] obs;

    typedef struct packed {
        logic        mr;
        logic        eqv;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [71:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    multicycle_controller dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .eq(eq), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .IorD(iord_a), .IRWrite(irw_a), .MemRead(mrd_a), .MemWrite(mwr_a),
        .RegWrite(rgw_a), .ALUsrcA(asa_a), .RegDst(rdst_a), .MemtoReg(m2r_a), .ALUsrcB(asb_a),
        .PCsrc(pcs_a), .ALUoperation(alu_a), .state(st_a), .illegal(ill_a), .timeout(to_a)
    );

    multicycle_controller #(.MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .eq(eq), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .IorD(iord_b), .IRWrite(irw_b), .MemRead(mrd_b), .MemWrite(mwr_b),
        .RegWrite(rgw_b), .ALUsrcA(asa_b), .RegDst(rdst_b), .MemtoReg(m2r_b), .ALUsrcB(asb_b),
        .PCsrc(pcs_b), .ALUoperation(alu_b), .state(st_b), .illegal(ill_b), .timeout(to_b)
    );

    multicycle_controller #(.ENABLE_JAL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .eq(eq), .mem_ready(mem_ready),
        .PCWrite(pcw_c), .IorD(iord_c), .IRWrite(irw_c), .MemRead(mrd_c), .MemWrite(mwr_c),
        .RegWrite(rgw_c), .ALUsrcA(asa_c), .RegDst(rdst_c), .MemtoReg(m2r_c), .ALUsrcB(asb_c),
        .PCsrc(pcs_c), .ALUoperation(alu_c), .state(st_c), .illegal(ill_c), .timeout(to_c)
    );

    assign vec_a = {st_a, pcw_a, iord_a, irw_a, mrd_a, mwr_a, rgw_a, asa_a,
                    rdst_a, m2r_a, asb_a, pcs_a, alu_a, ill_a, to_a};
    assign vec_b = {st_b, pcw_b, iord_b, irw_b, mrd_b, mwr_b, rgw_b, asa_b,
                    rdst_b, m2r_b, asb_b, pcs_b, alu_b, ill_b, to_b};
    assign vec_c = {st_c, pcw_c, iord_c, irw_c, mrd_c, mwr_c, rgw_c, asa_c,
                    rdst_c, m2r_c, asb_c, pcs_c, alu_c, ill_c, to_c};
    assign obs   = {vec_a, vec_b, vec_c};

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Expected output vector. en = {PCWrite,IorD,IRWrite,MemRead,MemWrite,RegWrite,ALUsrcA}.
    function automatic logic [23:0] ev(input logic [3:0] st, input logic [6:0] en,
                                       input logic [1:0] rdst, input logic [1:0] m2r,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [2:0] alu, input logic ill, input logic to);
        return {st, en, rdst, m2r, asb, pcs, alu, ill, to};
    endfunction

    function automatic logic [23:0] e_fetch_wait();
        return ev(4'd0, 7'b0001000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_fetch_rdy();
        return ev(4'd0, 7'b1011000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_decode();
        return ev(4'd1, 7'b0000000, 2'b00, 2'b00, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_memadr();
        return ev(4'd2, 7'b0000001, 2'b00, 2'b00, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_memrd();
        return ev(4'd3, 7'b0101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_memwb();
        return ev(4'd4, 7'b0000010, 2'b00, 2'b01, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_memwr();
        return ev(4'd5, 7'b0100100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_exec(input logic [2:0] alu);
        return ev(4'd6, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, alu, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_aluwb();
        return ev(4'd7, 7'b0000010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_branch(input logic pcw);
        return ev(4'd8, {pcw, 6'b000001}, 2'b00, 2'b00, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_jump(input logic jal);
        return ev(4'd9, {1'b1, 4'b0000, jal, 1'b0}, jal ? 2'b10 : 2'b00,
                  jal ? 2'b10 : 2'b00, 2'b00, 2'b10, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_immex(input logic [2:0] alu);
        return ev(4'd10, 7'b0000001, 2'b00, 2'b00, 2'b10, 2'b00, alu, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_immwb();
        return ev(4'd11, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] e_trap(input logic ill, input logic to);
        return ev(4'd12, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, ill, to);
    endfunction

    // Queue one cycle of stimulus with the expected outputs of a, b and c.
    task automatic push3(input logic mr, input logic eqv, input logic [5:0] op,
                         input logic [5:0] fn, input logic [23:0] ea,
                         input logic [23:0] eb, input logic [23:0] ec);
        sb_t e;
        e.mr  = mr;
        e.eqv = eqv;
        e.op  = op;
        e.fn  = fn;
        e.exp = {ea, eb, ec};
        sb.push_back(e);
    endtask

    task automatic push1(input logic mr, input logic eqv, input logic [5:0] op,
                         input logic [5:0] fn, input logic [23:0] e);
        push3(mr, eqv, op, fn, e, e, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // After reset every controller sits in FETCH with clean flags.
    task automatic test_reset();
        int  n = 0;
        sb_t e;
        do_reset();
        push1(1'b0, 1'b0, 6'd0, 6'd0, e_fetch_wait());
        push1(1'b0, 1'b0, 6'd0, 6'd0, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL reset cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // add with mem_ready held high throughout; it is ignored outside memory states.
    task automatic test_add();
        int  n = 0;
        sb_t e;
        push1(1'b1, 1'b0, 6'b000000, 6'b100000, e_fetch_rdy());
        push1(1'b1, 1'b0, 6'b000000, 6'b100000, e_decode());
        push1(1'b1, 1'b0, 6'b000000, 6'b100000, e_exec(3'b010));
        push1(1'b1, 1'b0, 6'b000000, 6'b100000, e_aluwb());
        push1(1'b0, 1'b0, 6'b000000, 6'b100000, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL add cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // Every legal R-type func, back to back, with its ALU operation in EXEC.
    task automatic test_rtype_ops();
        int         n = 0;
        sb_t        e;
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            push1(1'b1, 1'b0, 6'b000000, fns[i], e_fetch_rdy());
            push1(1'b0, 1'b0, 6'b000000, fns[i], e_decode());
            push1(1'b0, 1'b0, 6'b000000, fns[i], e_exec(ops[i]));
            push1(1'b0, 1'b0, 6'b000000, fns[i], e_aluwb());
        end
        push1(1'b0, 1'b0, 6'b000000, 6'b100000, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL rtype_ops cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // lw with mem_ready three cycles late. On b the ready arrives on the same
    // cycle its 4-cycle limit is reached, and the load must still complete.
    task automatic test_lw_delay();
        int  n = 0;
        sb_t e;
        push1(1'b1, 1'b0, 6'b100011, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b100011, 6'd0, e_decode());
        push1(1'b0, 1'b0, 6'b100011, 6'd0, e_memadr());
        for (int i = 0; i < 3; i++) push1(1'b0, 1'b0, 6'b100011, 6'd0, e_memrd());
        push1(1'b1, 1'b0, 6'b100011, 6'd0, e_memrd());
        push1(1'b0, 1'b0, 6'b100011, 6'd0, e_memwb());
        push1(1'b0, 1'b0, 6'b100011, 6'd0, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL lw_delay cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        int  n = 0;
        sb_t e;
        push1(1'b1, 1'b0, 6'b101011, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b101011, 6'd0, e_decode());
        push1(1'b0, 1'b0, 6'b101011, 6'd0, e_memadr());
        push1(1'b0, 1'b0, 6'b101011, 6'd0, e_memwr());
        push1(1'b1, 1'b0, 6'b101011, 6'd0, e_memwr());
        push1(1'b0, 1'b0, 6'b101011, 6'd0, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL sw cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // beq/bne with eq both ways: PCWrite follows eq for beq, ~eq for bne.
    task automatic test_branch();
        int         n = 0;
        sb_t        e;
        logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic       eqs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            push1(1'b1, eqs[i], ops[i], 6'd0, e_fetch_rdy());
            push1(1'b0, eqs[i], ops[i], 6'd0, e_decode());
            push1(1'b0, eqs[i], ops[i], 6'd0, e_branch(pcw[i]));
        end
        push1(1'b0, 1'b0, 6'b000100, 6'd0, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL branch cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_immediate();
        int  n = 0;
        sb_t e;
        push1(1'b1, 1'b0, 6'b001000, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b001000, 6'd0, e_decode());
        push1(1'b0, 1'b0, 6'b001000, 6'd0, e_immex(3'b010));
        push1(1'b0, 1'b0, 6'b001000, 6'd0, e_immwb());
        push1(1'b1, 1'b0, 6'b001100, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b001100, 6'd0, e_decode());
        push1(1'b0, 1'b0, 6'b001100, 6'd0, e_immex(3'b000));
        push1(1'b0, 1'b0, 6'b001100, 6'd0, e_immwb());
        push1(1'b0, 1'b0, 6'b001100, 6'd0, e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL immediate cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // j is legal everywhere. jal links on a and b but traps as illegal on c.
    task automatic test_jump();
        int  n = 0;
        sb_t e;
        push1(1'b1, 1'b0, 6'b000010, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b000010, 6'd0, e_decode());
        push1(1'b0, 1'b0, 6'b000010, 6'd0, e_jump(1'b0));
        push1(1'b1, 1'b0, 6'b000011, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b000011, 6'd0, e_decode());
        push3(1'b0, 1'b0, 6'b000011, 6'd0, e_jump(1'b1), e_jump(1'b1), e_trap(1'b1, 1'b0));
        push3(1'b0, 1'b0, 6'b000011, 6'd0, e_fetch_wait(), e_fetch_wait(), e_trap(1'b1, 1'b0));
        push3(1'b1, 1'b0, 6'b000011, 6'd0, e_fetch_rdy(), e_fetch_rdy(), e_trap(1'b1, 1'b0));
        push3(1'b0, 1'b0, 6'b000011, 6'd0, e_decode(), e_decode(), e_trap(1'b1, 1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL jump cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // Illegal func and illegal opcode both trap from DECODE with RegWrite never
    // raised. TRAP ignores mem_ready, and reset clears the flag.
    task automatic test_illegal();
        int  n = 0;
        sb_t e;
        do_reset();
        push1(1'b1, 1'b0, 6'b000000, 6'b000111, e_fetch_rdy());
        push1(1'b1, 1'b0, 6'b000000, 6'b000111, e_decode());
        push1(1'b1, 1'b0, 6'b000000, 6'b000111, e_trap(1'b1, 1'b0));
        push1(1'b0, 1'b0, 6'b000000, 6'b000111, e_trap(1'b1, 1'b0));
        push1(1'b1, 1'b1, 6'b100011, 6'b100000, e_trap(1'b1, 1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL illegal_func cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
        do_reset();
        n = 0;
        push1(1'b1, 1'b0, 6'b111111, 6'd0, e_fetch_rdy());
        push1(1'b0, 1'b0, 6'b111111, 6'd0, e_decode());
        push1(1'b0, 1'b0, 6'b111111, 6'd0, e_trap(1'b1, 1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL illegal_op cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // FETCH with no mem_ready: b traps after 4 cycles. A reset in the middle
    // of a's wait clears its counter, and a then traps after its own 15 cycles.
    task automatic test_timeout();
        int  n = 0;
        sb_t e;
        do_reset();
        for (int i = 0; i < 4; i++) push1(1'b0, 1'b0, 6'd0, 6'd0, e_fetch_wait());
        for (int i = 0; i < 2; i++)
            push3(1'b0, 1'b0, 6'd0, 6'd0, e_fetch_wait(), e_trap(1'b0, 1'b1), e_fetch_wait());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL timeout cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) push1(1'b0, 1'b0, 6'd0, 6'd0, e_fetch_wait());
        for (int i = 0; i < 11; i++)
            push3(1'b0, 1'b0, 6'd0, 6'd0, e_fetch_wait(), e_trap(1'b0, 1'b1), e_fetch_wait());
        push3(1'b0, 1'b0, 6'd0, 6'd0, e_trap(1'b0, 1'b1), e_trap(1'b0, 1'b1), e_trap(1'b0, 1'b1));
        push3(1'b1, 1'b0, 6'd0, 6'd0, e_trap(1'b0, 1'b1), e_trap(1'b0, 1'b1), e_trap(1'b0, 1'b1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; eq = e.eqv; opcode = e.op; func = e.fn;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("[TB] FAIL timeout_after_rst cycle %0d actual=%h required=%h", n, obs, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    // Scenario sequence. Tests run back to back without resets unless a
    // scenario needs a clean counter or flags.
    initial begin
        rst       = 1'b1;
        opcode    = 6'd0;
        func      = 6'd0;
        eq        = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_rtype_ops();
        test_lw_delay();
        test_sw();
        test_branch();
        test_immediate();
        test_jump();
        test_illegal();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
